dtack_gen: RTL and testbench

DTACK_GEN -- requirements
Module: dtack_gen

---
 rtl/dtack_gen.sv | 127 ++++++++++++
 tb/tb_dtack_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtack_gen.sv
// 68000 DTACK generator: synchronizes the bus strobes, inserts per-region wait
// states and drives registered dtack_n, peripheral strobes and watchdog clear.
module dtack_gen #(
  parameter logic [3:0] WAIT_ROM = 4'd2,
  parameter logic [3:0] WAIT_RAM = 4'd0,
  parameter logic [3:0] WAIT_IO  = 4'd4
) (
  input  logic clk,
  input  logic clr,
  input  logic as_n,
  input  logic uds_n,
  input  logic lds_n,
  input  logic rw,
  input  logic cs_rom,
  input  logic cs_ram,
  input  logic cs_io,
  input  logic io_ready,
  output logic dtack_n,
  output logic rd_n,
  output logic wr_n,
  output logic wd_clr,
  output logic dec_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_ERR} state_t;
  typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_IO} region_t;

  state_t      state, state_nxt;
  region_t     region, region_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        rw_lat, rw_nxt;
  logic [1:0]  as_sync, uds_sync, lds_sync, rw_sync;
  logic        as_s, ds_s, rw_s;
  logic        one_sel, multi_sel, busy_nxt;

  // NOTE: every sequential block uses non-blocking assignments so all
  // registers sample pre-edge values; blocking here would collapse the
  // two synchronizer stages into one.
  always_ff @(posedge clk) begin
    if (clr) begin
      as_sync  <= 2'b11;
      uds_sync <= 2'b11;
      lds_sync <= 2'b11;
      rw_sync  <= 2'b11;
    end else begin
      as_sync  <= {as_sync[0], as_n};
      uds_sync <= {uds_sync[0], uds_n};
      lds_sync <= {lds_sync[0], lds_n};
      rw_sync  <= {rw_sync[0], rw};
    end
  end

  assign as_s = ~as_sync[1];
  assign ds_s = ~uds_sync[1] | ~lds_sync[1];
  assign rw_s = rw_sync[1];

  assign multi_sel = (cs_rom & cs_ram) | (cs_rom & cs_io) | (cs_ram & cs_io);
  assign one_sel   = (cs_rom | cs_ram | cs_io) & ~multi_sel;

  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which is what would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    region_nxt = region;
    rw_nxt     = rw_lat;
    case (state)
      S_IDLE: begin
        if (as_s && ds_s) begin
          if (multi_sel) begin
            state_nxt = S_ERR;
          end else if (one_sel) begin
            state_nxt = S_WAIT;
            rw_nxt    = rw_s;
            if (cs_rom) begin
              region_nxt = REG_ROM;
              cnt_nxt    = WAIT_ROM;
            end else if (cs_ram) begin
              region_nxt = REG_RAM;
              cnt_nxt    = WAIT_RAM;
            end else begin
              region_nxt = REG_IO;
              cnt_nxt    = WAIT_IO;
            end
          end
        end
      end
      S_WAIT: begin
        // A strobe negate here means the cycle was terminated by BERR.
        if (!as_s)                            state_nxt = S_IDLE;
        else if (cnt != 4'd0)                 cnt_nxt   = cnt - 4'd1;
        else if (region != REG_IO || io_ready) state_nxt = S_ACK;
      end
      S_ACK:   if (!as_s) state_nxt = S_IDLE;
      S_ERR:   if (!as_s) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy_nxt = (state_nxt == S_WAIT) || (state_nxt == S_ACK);

  // Outputs are registered from next-state so they change on the transition edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= S_IDLE;
      region  <= REG_ROM;
      cnt     <= 4'd0;
      rw_lat  <= 1'b1;
      dtack_n <= 1'b1;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      wd_clr  <= 1'b1;
      dec_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      region  <= region_nxt;
      cnt     <= cnt_nxt;
      rw_lat  <= rw_nxt;
      dtack_n <= (state_nxt != S_ACK);
      rd_n    <= ~(busy_nxt & rw_nxt);
      wr_n    <= ~(busy_nxt & ~rw_nxt);
      wd_clr  <= (state_nxt == S_ACK) || (state_nxt == S_IDLE && !as_s);
      dec_err <= (state_nxt == S_ERR);
    end
  end

endmodule

// File: tb/tb_dtack_gen.sv
// Self-checking bench for dtack_gen with default wait-state parameters; a
// scoreboard queue holds the expected strobe type and dtack latency per access.
module tb_dtack_gen;

  logic clk = 1'b0;
  logic clr, as_n, uds_n, lds_n, rw, cs_rom, cs_ram, cs_io, io_ready;
  logic dtack_n, rd_n, wr_n, wd_clr, dec_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic  is_read;
    int    lat;
    string name;
  } exp_t;

  exp_t sb[$];

  dtack_gen dut (
    .clk(clk), .clr(clr), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw(rw),
    .cs_rom(cs_rom), .cs_ram(cs_ram), .cs_io(cs_io), .io_ready(io_ready),
    .dtack_n(dtack_n), .rd_n(rd_n), .wr_n(wr_n), .wd_clr(wd_clr), .dec_err(dec_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic bus_idle();
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    cs_rom = 1'b0; cs_ram = 1'b0; cs_io = 1'b0; io_ready = 1'b0;
  endtask

  task automatic drive_cycle(input logic c_rom, input logic c_ram, input logic c_io,
                             input logic is_read);
    @(negedge clk);
    cs_rom = c_rom; cs_ram = c_ram; cs_io = c_io; rw = is_read;
    io_ready = 1'b0; as_n = 1'b0; uds_n = 1'b0;
  endtask

  // Returns the number of negedges until rd_n or wr_n goes low (0 if never).
  task automatic wait_entry(output int n_seen);
    n_seen = 0;
    for (int n = 1; n <= 8 && n_seen == 0; n++) begin
      @(negedge clk);
      if (rd_n === 1'b0 || wr_n === 1'b0) n_seen = n;
    end
  endtask

  task automatic test_reset();
    bus_idle();
    clr = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({dtack_n, rd_n, wr_n, wd_clr, dec_err} !== 5'b11110) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 11110", {dtack_n, rd_n, wr_n, wd_clr, dec_err});
    end
    clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dtack_n, rd_n, wr_n, wd_clr, dec_err} !== 5'b11110) begin
      errors++;
      $display("FAIL idle_after_reset: got %b, required 11110", {dtack_n, rd_n, wr_n, wd_clr, dec_err});
    end
  endtask

  task automatic run_access(input string name, input logic c_rom, input logic c_ram,
                            input logic c_io, input logic is_read, input int ready_at,
                            input int exp_lat);
    int   n_entry, m;
    bit   acked, pend_ok;
    exp_t e;
    sb.push_back('{is_read, exp_lat, name});
    drive_cycle(c_rom, c_ram, c_io, is_read);
    wait_entry(n_entry);
    checks++;
    if (n_entry != 3) begin
      errors++;
      $display("FAIL %s_entry: strobe after %0d clocks, required 3", name, n_entry);
    end
    checks++;
    if ((is_read ? {rd_n, wr_n} : {wr_n, rd_n}) !== 2'b01) begin
      errors++;
      $display("FAIL %s_strobe_entry: rd_n=%b wr_n=%b, required %s strobe only", name, rd_n, wr_n,
               is_read ? "rd" : "wr");
    end
    m = 0; acked = 1'b0; pend_ok = 1'b1;
    while (!acked && m < 40) begin
      if (m == 0) rw = ~is_read;
      if (c_io && m == ready_at) io_ready = 1'b1;
      @(negedge clk);
      m++;
      if (dtack_n === 1'b0) acked = 1'b1;
      else if (wd_clr !== 1'b0 || dec_err !== 1'b0) pend_ok = 1'b0;
    end
    checks++;
    if (!pend_ok) begin
      errors++;
      $display("FAIL %s_pending: wd_clr or dec_err high while waiting, required wd_clr=0 dec_err=0", name);
    end
    e = sb.pop_front();
    checks++;
    if (!acked || m != e.lat) begin
      errors++;
      $display("FAIL %s_latency: dtack after %0d clocks (acked=%0d), required %0d", e.name, m, acked, e.lat);
    end
    checks++;
    if ((e.is_read ? {rd_n, wr_n} : {wr_n, rd_n}) !== 2'b01 || wd_clr !== 1'b1) begin
      errors++;
      $display("FAIL %s_ack_outputs: rd_n=%b wr_n=%b wd_clr=%b, required latched strobe low and wd_clr=1",
               name, rd_n, wr_n, wd_clr);
    end
    bus_idle();
    repeat (2) @(negedge clk);
    checks++;
    if (dtack_n !== 1'b0) begin
      errors++;
      $display("FAIL %s_dtack_hold: dtack_n=%b before as_s negate, required 0", name, dtack_n);
    end
    @(negedge clk);
    checks++;
    if ({dtack_n, rd_n, wr_n, wd_clr} !== 4'b1111) begin
      errors++;
      $display("FAIL %s_release: got %b, required 1111", name, {dtack_n, rd_n, wr_n, wd_clr});
    end
  endtask

  task automatic test_ram_read();
    run_access("ram_read", 1'b0, 1'b1, 1'b0, 1'b1, 0, 1);
  endtask

  task automatic test_rom_write();
    run_access("rom_write", 1'b1, 1'b0, 1'b0, 1'b0, 0, 3);
  endtask

  task automatic test_io_late_ready();
    run_access("io_late", 1'b0, 1'b0, 1'b1, 1'b1, 10, 11);
  endtask

  task automatic test_io_early_ready();
    run_access("io_early", 1'b0, 1'b0, 1'b1, 1'b0, 0, 5);
  endtask

  task automatic test_back_to_back();
    run_access("b2b_ram_wr", 1'b0, 1'b1, 1'b0, 1'b0, 0, 1);
    run_access("b2b_rom_rd", 1'b1, 1'b0, 1'b0, 1'b1, 0, 3);
    run_access("b2b_ram_rd", 1'b0, 1'b1, 1'b0, 1'b1, 0, 1);
  endtask

  task automatic test_unmapped();
    bit ok, cleared;
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ({dtack_n, rd_n, wr_n, wd_clr} !== 4'b1110) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL unmapped_pending: got %b, required dtack_n rd_n wr_n wd_clr = 1110",
               {dtack_n, rd_n, wr_n, wd_clr});
    end
    bus_idle();
    cleared = 1'b0;
    for (int i = 0; i < 3 && !cleared; i++) begin
      @(negedge clk);
      if (wd_clr === 1'b1) cleared = 1'b1;
    end
    checks++;
    if (!cleared) begin
      errors++;
      $display("FAIL unmapped_wd_clr: wd_clr=%b after 3 clocks, required 1", wd_clr);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_dec_err();
    int  n_seen;
    bit  ok;
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    n_seen = 0;
    for (int n = 1; n <= 8 && n_seen == 0; n++) begin
      @(negedge clk);
      if (dec_err === 1'b1) n_seen = n;
    end
    checks++;
    if (n_seen != 3) begin
      errors++;
      $display("FAIL dec_err_entry: dec_err after %0d clocks, required 3", n_seen);
    end
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if ({dec_err, dtack_n, rd_n, wr_n, wd_clr} !== 5'b11110) ok = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL dec_err_hold: got %b, required dec_err dtack_n rd_n wr_n wd_clr = 11110",
               {dec_err, dtack_n, rd_n, wr_n, wd_clr});
    end
    bus_idle();
    repeat (2) @(negedge clk);
    checks++;
    if (dec_err !== 1'b1) begin
      errors++;
      $display("FAIL dec_err_early_clear: dec_err=%b before as_s negate, required 1", dec_err);
    end
    @(negedge clk);
    checks++;
    if ({dec_err, wd_clr} !== 2'b01) begin
      errors++;
      $display("FAIL dec_err_clear: dec_err wd_clr = %b, required 01", {dec_err, wd_clr});
    end
  endtask

  task automatic test_abort();
    int n_entry;
    bit dtack_seen;
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    wait_entry(n_entry);
    checks++;
    if (n_entry != 3) begin
      errors++;
      $display("FAIL abort_entry: strobe after %0d clocks, required 3", n_entry);
    end
    repeat (2) @(negedge clk);
    as_n = 1'b1; uds_n = 1'b1;
    dtack_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dtack_n !== 1'b1) dtack_seen = 1'b1;
    end
    checks++;
    if (dtack_seen) begin
      errors++;
      $display("FAIL abort_no_dtack: dtack_n pulsed low, required it to stay 1");
    end
    checks++;
    if ({rd_n, wr_n, wd_clr} !== 3'b111) begin
      errors++;
      $display("FAIL abort_idle: rd_n wr_n wd_clr = %b, required 111", {rd_n, wr_n, wd_clr});
    end
    bus_idle();
  endtask

  task automatic test_clr_in_ack();
    int n_entry;
    bit acked;
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b1);
    wait_entry(n_entry);
    acked = 1'b0;
    for (int i = 0; i < 5 && !acked; i++) begin
      @(negedge clk);
      if (dtack_n === 1'b0) acked = 1'b1;
    end
    checks++;
    if (!acked) begin
      errors++;
      $display("FAIL clr_ack_reach: dtack_n=%b, required 0 before clr", dtack_n);
    end
    clr = 1'b1;
    bus_idle();
    @(negedge clk);
    checks++;
    if ({dtack_n, rd_n, wr_n, wd_clr, dec_err} !== 5'b11110) begin
      errors++;
      $display("FAIL clr_in_ack: got %b, required 11110", {dtack_n, rd_n, wr_n, wd_clr, dec_err});
    end
    clr = 1'b0;
    repeat (3) @(negedge clk);
    run_access("after_clr", 1'b0, 1'b1, 1'b0, 1'b1, 0, 1);
  endtask

  initial begin
    clr = 1'b1;
    bus_idle();
    test_reset();
    test_ram_read();
    test_rom_write();
    test_io_late_ready();
    test_io_early_ready();
    test_back_to_back();
    test_unmapped();
    test_dec_err();
    test_abort();
    test_clr_in_ack();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
